// File: rtl/hazard_ctrl_pkg.sv
// Shared widths, defaults and helpers for the hazard controller.
package hazard_ctrl_pkg;
  localparam int MD_LAT_DEF = 4;   // Hi/Lo producer latency in cycles
  localparam int REG_W      = 5;   // register index width
  localparam int MD_CNT_W   = 4;   // Hi/Lo busy counter width
  localparam int PERF_W     = 16;  // performance counter width

  // A match needs a real destination: register 0 is hardwired and never a hazard.
  function automatic logic reg_match(input logic [REG_W-1:0] dst,
                                     input logic [REG_W-1:0] src);
    return (dst != '0) && (dst == src);
  endfunction
endpackage

// File: rtl/hilo_busy_tracker.sv
// Counts down the remaining cycles until a mult/div result is in Hi/Lo.
module hilo_busy_tracker
  import hazard_ctrl_pkg::*;
#(
  parameter int MD_LAT = MD_LAT_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  output logic o_busy
);
  logic [MD_CNT_W-1:0] r_cnt;

  // Load latency on an accepted mult/div, otherwise drain toward zero; reset abandons the count.
  always_ff @(posedge i_clk) begin
    if (i_rst)             r_cnt <= '0;
    else if (i_load)       r_cnt <= MD_CNT_W'(MD_LAT);
    else if (r_cnt != '0)  r_cnt <= r_cnt - 1'b1;
  end

  assign o_busy = (r_cnt != '0);
endmodule

// File: rtl/hazard_ctrl.sv
// ID-stage hazard detection: load-use, branch-operand and Hi/Lo stalls,
// redirect flushes, and saturating stall/flush performance counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MD_LAT = MD_LAT_DEF
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [REG_W-1:0]  ID_Rs,
  input  logic [REG_W-1:0]  ID_Rt,
  input  logic              ID_UsesRt,
  input  logic              ID_IsBranch,
  input  logic              ID_IsMulDiv,
  input  logic              ID_ReadsHiLo,
  input  logic              BranchTaken,
  input  logic              Jump,
  input  logic              EX_MemRead,
  input  logic              EX_RegWrite,
  input  logic [REG_W-1:0]  EX_WriteReg,
  input  logic              MEM_MemRead,
  input  logic [REG_W-1:0]  MEM_WriteReg,
  output logic              PCWrite,
  output logic              IF_ID_Write,
  output logic              IF_ID_Write_Flush,
  output logic              ID_EX_Bubble,
  output logic [PERF_W-1:0] StallCount,
  output logic [PERF_W-1:0] FlushCount
);
  logic w_load_use, w_br_dep, w_md_busy, w_hilo_busy;
  logic w_stall, w_redirect, w_md_load;
  logic [PERF_W-1:0] r_stall_cnt, r_flush_cnt;

  // Hazard equations; Rt only counts for load-use when the instruction actually reads it.
  always_comb begin
    w_load_use = EX_MemRead &&
                 (reg_match(EX_WriteReg, ID_Rs) ||
                  (ID_UsesRt && reg_match(EX_WriteReg, ID_Rt)));
    w_br_dep   = ID_IsBranch &&
                 ((EX_RegWrite && (reg_match(EX_WriteReg, ID_Rs) ||
                                   reg_match(EX_WriteReg, ID_Rt))) ||
                  (MEM_MemRead && (reg_match(MEM_WriteReg, ID_Rs) ||
                                   reg_match(MEM_WriteReg, ID_Rt))));
    w_md_busy  = w_hilo_busy && (ID_ReadsHiLo || ID_IsMulDiv);
    w_stall    = w_load_use || w_br_dep || w_md_busy;
    w_redirect = (BranchTaken || Jump) && !w_stall;
  end

  // A mult stalled behind a busy unit is not accepted, so it must not reload the counter.
  assign w_md_load = ID_IsMulDiv && !w_stall;

  hilo_busy_tracker #(.MD_LAT(MD_LAT)) u_hilo (
    .i_clk  (Clock),
    .i_rst  (Reset),
    .i_load (w_md_load),
    .o_busy (w_hilo_busy)
  );

  // Pipeline control: reset freezes everything, stall beats redirect.
  always_comb begin
    PCWrite           = 1'b1;
    IF_ID_Write       = 1'b1;
    IF_ID_Write_Flush = 1'b1;
    ID_EX_Bubble      = 1'b0;
    if (Reset) begin
      PCWrite           = 1'b0;
      IF_ID_Write       = 1'b0;
      IF_ID_Write_Flush = 1'b0;
      ID_EX_Bubble      = 1'b1;
    end else if (w_stall) begin
      PCWrite           = 1'b0;
      IF_ID_Write       = 1'b0;
      ID_EX_Bubble      = 1'b1;
    end else if (w_redirect) begin
      IF_ID_Write_Flush = 1'b0;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != '1))    r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_redirect && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign StallCount = r_stall_cnt;
  assign FlushCount = r_flush_cnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench: stimulus pushes hand-computed expectations, a monitor pops and compares.
module tb_hazard_ctrl;
  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [4:0]  ID_Rs = '0, ID_Rt = '0;
  logic        ID_UsesRt = 0, ID_IsBranch = 0, ID_IsMulDiv = 0, ID_ReadsHiLo = 0;
  logic        BranchTaken = 0, Jump = 0, EX_MemRead = 0, EX_RegWrite = 0;
  logic [4:0]  EX_WriteReg = '0;
  logic        MEM_MemRead = 0;
  logic [4:0]  MEM_WriteReg = '0;
  logic        PCWrite, IF_ID_Write, IF_ID_Write_Flush, ID_EX_Bubble;
  logic [15:0] StallCount, FlushCount;

  hazard_ctrl #(.MD_LAT(4)) dut (
    .Clock(Clock), .Reset(Reset), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
    .ID_UsesRt(ID_UsesRt), .ID_IsBranch(ID_IsBranch), .ID_IsMulDiv(ID_IsMulDiv),
    .ID_ReadsHiLo(ID_ReadsHiLo), .BranchTaken(BranchTaken), .Jump(Jump),
    .EX_MemRead(EX_MemRead), .EX_RegWrite(EX_RegWrite), .EX_WriteReg(EX_WriteReg),
    .MEM_MemRead(MEM_MemRead), .MEM_WriteReg(MEM_WriteReg),
    .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write), .IF_ID_Write_Flush(IF_ID_Write_Flush),
    .ID_EX_Bubble(ID_EX_Bubble), .StallCount(StallCount), .FlushCount(FlushCount)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    string nm;
    logic  pcw, ifw, fl, bub;
    int    sc, fc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input string f, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s.%s: got %0d expected %0d", nm, f, act, req);
    end
  endtask

  // Monitor: control outputs are combinational and valid every cycle, so each
  // falling edge consumes one pending expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clock);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk(e.nm, "PCWrite",   int'(PCWrite),           int'(e.pcw));
        chk(e.nm, "IF_ID_Wr",  int'(IF_ID_Write),       int'(e.ifw));
        chk(e.nm, "Flush_n",   int'(IF_ID_Write_Flush), int'(e.fl));
        chk(e.nm, "Bubble",    int'(ID_EX_Bubble),      int'(e.bub));
        chk(e.nm, "StallCnt",  int'(StallCount),        e.sc);
        chk(e.nm, "FlushCnt",  int'(FlushCount),        e.fc);
      end
    end
  end

  // One cycle of stimulus plus its expected outputs (counts are the values
  // visible during that cycle, i.e. after all earlier edges).
  task automatic step(input string nm, input bit rst,
                      input int rs, input int rt, input bit ur,
                      input bit br, input bit md, input bit rh,
                      input bit bt, input bit jp,
                      input bit exmr, input bit exrw, input int exwr,
                      input bit memmr, input int memwr,
                      input bit pcw, input bit ifw, input bit fl, input bit bub,
                      input int sc, input int fc);
    exp_t e;
    @(posedge Clock);
    #1;
    Reset = rst; ID_Rs = 5'(rs); ID_Rt = 5'(rt); ID_UsesRt = ur;
    ID_IsBranch = br; ID_IsMulDiv = md; ID_ReadsHiLo = rh;
    BranchTaken = bt; Jump = jp; EX_MemRead = exmr; EX_RegWrite = exrw;
    EX_WriteReg = 5'(exwr); MEM_MemRead = memmr; MEM_WriteReg = 5'(memwr);
    e.nm = nm; e.pcw = pcw; e.ifw = ifw; e.fl = fl; e.bub = bub; e.sc = sc; e.fc = fc;
    q.push_back(e);
  endtask

  initial begin
    //     name         rst rs rt ur br md rh bt jp exmr exrw exwr memmr memwr  pcw ifw fl bub sc fc
    step("rst_a",        1, 0, 0, 0, 0, 0, 0, 1, 0,  0,   0,   0,   0,    0,    0,  0,  0, 1,  0, 0);
    step("rst_b",        1, 8, 0, 0, 0, 0, 0, 0, 0,  1,   0,   8,   0,    0,    0,  0,  0, 1,  0, 0);
    step("idle0",        0, 0, 0, 0, 0, 0, 0, 0, 0,  0,   0,   0,   0,    0,    1,  1,  1, 0,  0, 0);
    step("loaduse_rs",   0, 8, 0, 0, 0, 0, 0, 0, 0,  1,   0,   8,   0,    0,    0,  0,  1, 1,  0, 0);
    step("after_lu",     0, 0, 0, 0, 0, 0, 0, 0, 0,  0,   0,   0,   0,    0,    1,  1,  1, 0,  1, 0);
    step("loaduse_rt",   0, 1, 9, 1, 0, 0, 0, 0, 0,  1,   0,   9,   0,    0,    0,  0,  1, 1,  1, 0);
    step("rt_unused",    0, 1, 9, 0, 0, 0, 0, 0, 0,  1,   0,   9,   0,    0,    1,  1,  1, 0,  2, 0);
    step("zero_reg",     0, 0, 0, 1, 0, 0, 0, 0, 0,  1,   0,   0,   0,    0,    1,  1,  1, 0,  2, 0);
    step("br_taken",     0, 0, 0, 0, 0, 0, 0, 1, 0,  0,   0,   0,   0,    0,    1,  1,  0, 0,  2, 0);
    step("after_br",     0, 0, 0, 0, 0, 0, 0, 0, 0,  0,   0,   0,   0,    0,    1,  1,  1, 0,  2, 1);
    step("jump",         0, 0, 0, 0, 0, 0, 0, 0, 1,  0,   0,   0,   0,    0,    1,  1,  0, 0,  2, 1);
    step("brdep_ex",     0, 5, 0, 0, 1, 0, 0, 1, 0,  0,   1,   5,   0,    0,    0,  0,  1, 1,  2, 2);
    step("brdep_mem",    0, 7, 0, 0, 1, 0, 0, 1, 0,  0,   0,   0,   1,    7,    0,  0,  1, 1,  3, 2);
    step("br_nomatch",   0, 5, 0, 0, 1, 0, 0, 1, 0,  0,   1,   6,   0,    0,    1,  1,  0, 0,  4, 2);
    step("wr_nobranch",  0, 5, 0, 0, 0, 0, 0, 0, 0,  0,   1,   5,   0,    0,    1,  1,  1, 0,  4, 3);
    step("mult0",        0, 0, 0, 0, 0, 1, 0, 0, 0,  0,   0,   0,   0,    0,    1,  1,  1, 0,  4, 3);
    step("mfhi_c1",      0, 0, 0, 0, 0, 0, 1, 0, 0,  0,   0,   0,   0,    0,    0,  0,  1, 1,  4, 3);
    step("mfhi_c2",      0, 0, 0, 0, 0, 0, 1, 0, 0,  0,   0,   0,   0,    0,    0,  0,  1, 1,  5, 3);
    step("mfhi_c3",      0, 0, 0, 0, 0, 0, 1, 0, 0,  0,   0,   0,   0,    0,    0,  0,  1, 1,  6, 3);
    step("mfhi_c4",      0, 0, 0, 0, 0, 0, 1, 0, 0,  0,   0,   0,   0,    0,    0,  0,  1, 1,  7, 3);
    step("mfhi_c5",      0, 0, 0, 0, 0, 0, 1, 0, 0,  0,   0,   0,   0,    0,    1,  1,  1, 0,  8, 3);
    step("mult1",        0, 0, 0, 0, 0, 1, 0, 0, 0,  0,   0,   0,   0,    0,    1,  1,  1, 0,  8, 3);
    step("mult2_w4",     0, 0, 0, 0, 0, 1, 0, 0, 0,  0,   0,   0,   0,    0,    0,  0,  1, 1,  8, 3);
    step("mult2_w3",     0, 0, 0, 0, 0, 1, 0, 0, 0,  0,   0,   0,   0,    0,    0,  0,  1, 1,  9, 3);
    step("mult2_w2",     0, 0, 0, 0, 0, 1, 0, 0, 0,  0,   0,   0,   0,    0,    0,  0,  1, 1, 10, 3);
    step("mult2_w1",     0, 0, 0, 0, 0, 1, 0, 0, 0,  0,   0,   0,   0,    0,    0,  0,  1, 1, 11, 3);
    step("mult2_go",     0, 0, 0, 0, 0, 1, 0, 0, 0,  0,   0,   0,   0,    0,    1,  1,  1, 0, 12, 3);
    step("reload_chk",   0, 0, 0, 0, 0, 0, 1, 1, 0,  0,   0,   0,   0,    0,    0,  0,  1, 1, 12, 3);
    step("idle_cnt2",    0, 0, 0, 0, 0, 0, 0, 0, 0,  0,   0,   0,   0,    0,    1,  1,  1, 0, 13, 3);
    step("rst_mid",      1, 0, 0, 0, 0, 0, 1, 0, 1,  0,   0,   0,   0,    0,    0,  0,  0, 1, 13, 3);
    step("mfhi_postrst", 0, 0, 0, 0, 0, 0, 1, 0, 0,  0,   0,   0,   0,    0,    1,  1,  1, 0,  0, 0);
    step("idle_end",     0, 0, 0, 0, 0, 0, 0, 0, 0,  0,   0,   0,   0,    0,    1,  1,  1, 0,  0, 0);

    // Bounded drain of outstanding expectations.
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge Clock);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MD_LAT, default 4: Hi/Lo-producer latency in cycles, legal range 1..15.
REQ-002 Clock  in  1  sole clock; all state updates on its rising edge.
REQ-003 Reset  in  1  synchronous, active-high.
REQ-004 ID_Rs, ID_Rt  in  5 each  source registers of the instruction in ID.
REQ-005 ID_UsesRt  in  1  ID instruction reads Rt.
REQ-006 ID_IsBranch  in  1  ID instruction is a branch resolved in ID.
REQ-007 ID_IsMulDiv  in  1  ID instruction writes Hi/Lo (mult/div).
REQ-008 ID_ReadsHiLo  in  1  ID instruction reads Hi/Lo (mfhi/mflo/madd).
REQ-009 BranchTaken, Jump  in  1 each  redirect resolved in ID this cycle.
REQ-010 EX_MemRead, EX_RegWrite  in  1 each; EX_WriteReg  in  5  destination register in EX.
REQ-011 MEM_MemRead  in  1; MEM_WriteReg  in  5  destination register in MEM.
REQ-012 PCWrite  out  1  1 = PC advances.
REQ-013 IF_ID_Write  out  1  1 = IF/ID loads; 0 = IF/ID holds its saved contents.
REQ-014 IF_ID_Write_Flush  out  1  active-low: 0 = IF/ID clears to zero.
REQ-015 ID_EX_Bubble  out  1  1 = ID/EX control fields forced to zero.
REQ-016 StallCount, FlushCount  out  16 each  saturating performance counters.

Function
REQ-017 A register match SHALL require a nonzero destination; register 0 never matches.
REQ-018 LoadUse SHALL be EX_MemRead and EX_WriteReg matching ID_Rs, or matching ID_Rt when ID_UsesRt.
REQ-019 BrDep SHALL be ID_IsBranch and either (EX_RegWrite and EX_WriteReg matches) or (MEM_MemRead and MEM_WriteReg matches).
REQ-020 MdBusy SHALL be the internal counter being nonzero and (ID_ReadsHiLo or ID_IsMulDiv).
REQ-021 Stall = LoadUse or BrDep or MdBusy; outputs during Stall: PCWrite=0, IF_ID_Write=0, IF_ID_Write_Flush=1, ID_EX_Bubble=1.
REQ-022 Redirect = (BranchTaken or Jump) and not Stall; outputs: PCWrite=1, IF_ID_Write=1, IF_ID_Write_Flush=0, ID_EX_Bubble=0.
REQ-023 Stall SHALL take priority over Redirect; BranchTaken and Jump are ignored in any stall cycle.
REQ-024 Otherwise the outputs SHALL be PCWrite=1, IF_ID_Write=1, IF_ID_Write_Flush=1, ID_EX_Bubble=0.
REQ-025 All control outputs SHALL be combinational from the inputs and the current state, with zero latency, so they are valid before the edge at which the pipeline register samples them.
REQ-026 Counter (4 bits): when ID_IsMulDiv and not Stall, load MD_LAT; else if nonzero, decrement by 1; else hold 0.
REQ-027 A Hi/Lo reader entering ID the cycle after an accepted mult SHALL stall exactly MD_LAT cycles.
REQ-028 A second mult arriving while the counter is nonzero SHALL stall until the counter reaches 0, then reload it.
REQ-029 StallCount SHALL increment on each Stall cycle; FlushCount on each Redirect cycle; both saturate at 16'hFFFF.

Reset
REQ-030 While Reset=1: PCWrite=0, IF_ID_Write=0, IF_ID_Write_Flush=0, ID_EX_Bubble=1, regardless of the other inputs.
REQ-031 On the edge at which Reset is sampled high: counter, StallCount and FlushCount SHALL be set to 0.
REQ-032 Reset asserted while the counter is nonzero SHALL abandon the count; the first cycle after reset is normal (no stall).

Structure
REQ-033 A shared package SHALL hold the MD_LAT default, the register-index width (5) and the counter widths.
REQ-034 The Hi/Lo busy counter SHALL be a sub-module named hilo_busy_tracker; the hazard equations and perf counters stay at top level.

Verification
REQ-035 Load-use: EX_MemRead=1, EX_WriteReg=8, ID_Rs=8 -> one cycle of PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1; StallCount=1.
REQ-036 Zero register: EX_MemRead=1, EX_WriteReg=0, ID_Rs=0 -> no stall.
REQ-037 Taken branch: BranchTaken=1 with no hazard -> IF_ID_Write_Flush=0 for one cycle; FlushCount=1.
REQ-038 Branch dependence: ID_IsBranch=1, BranchTaken=1, EX_RegWrite=1, EX_WriteReg=ID_Rs=5 -> Stall, IF_ID_Write_Flush=1, FlushCount unchanged.
REQ-039 Mult then mfhi (MD_LAT=4): mult accepted at cycle 0, mfhi in ID from cycle 1 -> stall cycles 1-4, proceeds at cycle 5.
REQ-040 Reset mid-count: assert Reset at counter=2 -> all counters read 0, and mfhi issued after reset does not stall.
